// File: rtl/aes_pkg.sv
// Shared AES sequencing definitions: round counts, bus widths, block type and FSM encoding.
package aes_pkg;

    localparam int AES_NR        = 10;
    localparam int AES_BLK_W     = 128;
    localparam int AES_KIDX_W    = 4;
    localparam int AES_ROUND_LAT = 2;

    typedef logic [AES_BLK_W-1:0] aes_blk_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_state_e;

endpackage

// File: rtl/aes_round_timer.sv
// Per-round wait counter: counts 0..ROUND_LAT while run is high and pulses expire on the last count.
module aes_round_timer #(
    parameter int ROUND_LAT = 2,
    parameter int CW        = (ROUND_LAT > 0) ? $clog2(ROUND_LAT + 1) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          run,
    output logic          expire,
    output logic [CW-1:0] count
);

    logic [CW-1:0] cnt_q;

    assign count  = cnt_q;
    assign expire = run && (cnt_q == CW'(ROUND_LAT));

    // Reloads to zero on expiry, so the counter never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (start || expire) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/aes_round_sched.sv
// Iterative AES-128 round sequencer driving one shared external round datapath and key store.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid never depends on ready.
module aes_round_sched
    import aes_pkg::*;
#(
    parameter int NR        = AES_NR,
    parameter int ROUND_LAT = AES_ROUND_LAT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  aes_blk_t              in_data,
    output logic [AES_KIDX_W-1:0] key_idx,
    input  aes_blk_t              key_data,
    output aes_blk_t              rnd_state,
    output aes_blk_t              rnd_key,
    output logic                  rnd_final,
    input  aes_blk_t              rnd_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output aes_blk_t              out_data,
    output logic                  busy,
    output aes_state_e            dbg_state
);

    localparam int RCW = $clog2(NR + 1);
    localparam int TCW = (ROUND_LAT > 0) ? $clog2(ROUND_LAT + 1) : 1;

    aes_state_e     state_q, state_d;
    logic [RCW-1:0] round_q, round_d;
    aes_blk_t       blk_q, blk_d;
    logic           tmr_start, tmr_run, tmr_expire;
    logic [TCW-1:0] tmr_count;

    aes_round_timer #(
        .ROUND_LAT (ROUND_LAT),
        .CW        (TCW)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (tmr_start),
        .run    (tmr_run),
        .expire (tmr_expire),
        .count  (tmr_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            round_q <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            blk_q   <= blk_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        blk_d     = blk_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        rnd_final = 1'b0;
        key_idx   = '0;
        tmr_start = 1'b0;
        tmr_run   = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                // key_idx is 0 here, so key_data is the whitening key.
                if (in_valid) begin
                    blk_d     = in_data ^ key_data;
                    round_d   = RCW'(1);
                    tmr_start = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                key_idx   = AES_KIDX_W'(round_q);
                rnd_final = (round_q == RCW'(NR));
                tmr_run   = 1'b1;
                if (tmr_expire) begin
                    blk_d = rnd_result;
                    if (round_q == RCW'(NR)) begin
                        round_d = '0;
                        state_d = DONE;
                    end else begin
                        round_d = round_q + RCW'(1);
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rnd_state = blk_q;
    assign rnd_key   = key_data;
    assign out_data  = (state_q == DONE) ? blk_q : '0;
    assign dbg_state = state_q;

endmodule
